div_q8_8: RTL



---
 rtl/div_q8_8.sv | 115 +++++++++++
 1 files changed

// File: rtl/div_q8_8.sv
// Sequential signed Q8.8 divider: (dividend << 8) / divisor, one quotient
// bit per clock using restoring division on magnitudes. Sign is applied
// afterwards and results saturate to the Q8.8 range. Latency is a fixed 25
// cycles from the accept edge, including divide-by-zero.
module div_q8_8 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t      state;
    logic        sign;
    logic        num_neg;
    logic [15:0] dvsr;
    logic [23:0] num;
    logic [23:0] quo;
    logic [16:0] rem;
    logic [4:0]  cnt;

    logic [15:0] dividend_mag;
    logic [15:0] divisor_mag;
    logic [17:0] trial;
    logic [16:0] diff;
    logic        fits;
    logic        pos_sat;
    logic        neg_sat;
    logic [15:0] quo_neg;

    assign busy = (state != IDLE);

    // Operand magnitudes, one restoring-division step and saturation tests
    always_comb begin
        dividend_mag = dividend[15] ? (~dividend + 16'd1) : dividend;
        divisor_mag  = divisor[15]  ? (~divisor  + 16'd1) : divisor;
        trial        = {rem, num[cnt]};
        fits         = (trial >= {2'b00, dvsr});
        diff         = trial[16:0] - {1'b0, dvsr};
        pos_sat      = |quo[23:15];
        neg_sat      = (|quo[23:16]) || (quo[15] && (|quo[14:0]));
        quo_neg      = (~quo[15:0]) + 16'd1;
    end

    // Control FSM and datapath registers; done/result/div_zero registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            sign     <= 1'b0;
            num_neg  <= 1'b0;
            dvsr     <= 16'd0;
            num      <= 24'd0;
            quo      <= 24'd0;
            rem      <= 17'd0;
            cnt      <= 5'd0;
            done     <= 1'b0;
            result   <= 16'h0000;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sign    <= dividend[15] ^ divisor[15];
                        num_neg <= dividend[15];
                        dvsr    <= divisor_mag;
                        num     <= {dividend_mag, 8'h00};
                        quo     <= 24'd0;
                        rem     <= 17'd0;
                        cnt     <= 5'd23;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    rem <= fits ? diff : trial[16:0];
                    quo <= {quo[22:0], fits};
                    if (cnt == 5'd0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                FIX: begin
                    if (dvsr == 16'd0) begin
                        result   <= num_neg ? 16'h8000 : 16'h7FFF;
                        div_zero <= 1'b1;
                    end else begin
                        if (sign) begin
                            result <= neg_sat ? 16'h8000 : quo_neg;
                        end else begin
                            result <= pos_sat ? 16'h7FFF : quo[15:0];
                        end
                        div_zero <= 1'b0;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
